// File: rtl/decoder_4to16_sync_if.sv
// Select/decode bus for the registered 4-to-16 decoder.
// The master drives the enable and index; the slave returns the one-hot and its valid flag.
interface decoder_4to16_sync_if;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned OUT_W = 16;

  logic             en;
  logic [IDX_W-1:0] a;
  logic [OUT_W-1:0] d;
  logic             valid;

  modport master (
    output en,
    output a,
    input  d,
    input  valid
  );

  modport slave (
    input  en,
    input  a,
    output d,
    output valid
  );
endinterface

// File: rtl/decoder_4to16_sync.sv
// Registered 4-to-16 one-hot decoder with enable and valid flag.
// ACTIVE_LOW inverts the whole output word, including its reset value.
module decoder_4to16_sync #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_4to16_sync_if.slave  bus
);
  localparam int unsigned OUT_W = 16;
  localparam logic [OUT_W-1:0] POL_MASK = ACTIVE_LOW ? '1 : '0;

  logic [OUT_W-1:0] onehot_c;
  logic [OUT_W-1:0] d_q;
  logic             valid_q;

  // Decode is combinational only up to the output register; a never reaches d directly.
  always_comb begin
    onehot_c = OUT_W'(1) << bus.a;
  end

  // d holds its last decode while en is low; valid marks only freshly decoded cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= POL_MASK;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        d_q <= onehot_c ^ POL_MASK;
      end
    end
  end

  assign bus.d     = d_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_decoder_4to16_sync.sv
// Directed bench for decoder_4to16_sync: one active-high and one active-low instance
// driven with the same enable/index stream.
module tb_decoder_4to16_sync;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  decoder_4to16_sync_if bus ();
  decoder_4to16_sync_if bus_al ();

  assign bus_al.en = bus.en;
  assign bus_al.a  = bus.a;

  decoder_4to16_sync #(.ACTIVE_LOW(1'b0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  decoder_4to16_sync #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] exp_tab [16];
  initial begin
    exp_tab = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                16'h0010, 16'h0020, 16'h0040, 16'h0080,
                16'h0100, 16'h0200, 16'h0400, 16'h0800,
                16'h1000, 16'h2000, 16'h4000, 16'h8000};
  end

  task automatic test_reset;
    rst_n  = 1'b1;
    bus.en = 1'b0;
    bus.a  = 4'd0;
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.d !== 16'h0000) $display("FAIL reset_d: got %h expected %h", bus.d, 16'h0000);
    else n_pass++;
    n_checks++;
    if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b expected %b", bus.valid, 1'b0);
    else n_pass++;
    n_checks++;
    if (bus_al.d !== 16'hFFFF) $display("FAIL reset_d_al: got %h expected %h", bus_al.d, 16'hFFFF);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.d !== 16'h0000 || bus.valid !== 1'b0)
      $display("FAIL release_idle: got d=%h valid=%b expected d=%h valid=%b",
               bus.d, bus.valid, 16'h0000, 1'b0);
    else n_pass++;
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.en = 1'b1;
      bus.a  = 4'(i);
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.d !== exp_tab[i] || bus.valid !== 1'b1 || $countones(bus.d) != 1)
        $display("FAIL sweep_a%0d: got d=%h valid=%b expected d=%h valid=%b",
                 i, bus.d, bus.valid, exp_tab[i], 1'b1);
      else n_pass++;
      n_checks++;
      if (bus_al.d !== ~exp_tab[i])
        $display("FAIL sweep_al_a%0d: got %h expected %h", i, bus_al.d, ~exp_tab[i]);
      else n_pass++;
    end
  endtask

  task automatic test_boundaries;
    @(negedge clk);
    bus.en = 1'b1;
    bus.a  = 4'd15;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.d !== 16'b1000_0000_0000_0000 || bus_al.d !== 16'h7FFF)
      $display("FAIL bound_a15: got d=%h d_al=%h expected d=%h d_al=%h",
               bus.d, bus_al.d, 16'h8000, 16'h7FFF);
    else n_pass++;
    @(negedge clk);
    bus.a = 4'd0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.d !== 16'b0000_0000_0000_0001 || bus_al.d !== 16'hFFFE)
      $display("FAIL bound_a0: got d=%h d_al=%h expected d=%h d_al=%h",
               bus.d, bus_al.d, 16'h0001, 16'hFFFE);
    else n_pass++;
  endtask

  task automatic test_hold;
    @(negedge clk);
    bus.en = 1'b1;
    bus.a  = 4'd5;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.d !== 16'h0020 || bus.valid !== 1'b1)
      $display("FAIL hold_load: got d=%h valid=%b expected d=%h valid=%b",
               bus.d, bus.valid, 16'h0020, 1'b1);
    else n_pass++;
    @(negedge clk);
    bus.en = 1'b0;
    bus.a  = 4'd9;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.d !== 16'h0020 || bus.valid !== 1'b0)
        $display("FAIL hold_cyc%0d: got d=%h valid=%b expected d=%h valid=%b",
                 c, bus.d, bus.valid, 16'h0020, 1'b0);
      else n_pass++;
    end
  endtask

  task automatic test_polarity;
    @(negedge clk);
    bus.en = 1'b1;
    bus.a  = 4'd3;
    #1;
    // Output must not follow a before the clock edge.
    n_checks++;
    if (bus.d !== 16'h0020 || bus_al.d !== 16'hFFDF)
      $display("FAIL no_comb_path: got d=%h d_al=%h expected d=%h d_al=%h",
               bus.d, bus_al.d, 16'h0020, 16'hFFDF);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_al.d !== 16'hFFF7 || bus.d !== 16'h0008)
      $display("FAIL polarity_a3: got d_al=%h d=%h expected d_al=%h d=%h",
               bus_al.d, bus.d, 16'hFFF7, 16'h0008);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.en = 1'b1;
    bus.a  = 4'd7;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.d !== 16'h0080) $display("FAIL mid_load: got %h expected %h", bus.d, 16'h0080);
    else n_pass++;
    @(negedge clk);
    bus.en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.d !== 16'h0000 || bus.valid !== 1'b0 || bus_al.d !== 16'hFFFF)
      $display("FAIL mid_reset: got d=%h valid=%b d_al=%h expected d=%h valid=%b d_al=%h",
               bus.d, bus.valid, bus_al.d, 16'h0000, 1'b0, 16'hFFFF);
    else n_pass++;
    #1 rst_n = 1'b1;
    bus.en = 1'b1;
    bus.a  = 4'd2;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.d !== 16'h0004 || bus.valid !== 1'b1)
      $display("FAIL mid_after: got d=%h valid=%b expected d=%h valid=%b",
               bus.d, bus.valid, 16'h0004, 1'b1);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_sweep();
    test_boundaries();
    test_hold();
    test_polarity();
    test_reset_mid();
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.valid !== 1'b0 || bus.d !== 16'h0004)
      $display("FAIL final_idle: got d=%h valid=%b expected d=%h valid=%b",
               bus.d, bus.valid, 16'h0004, 1'b0);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
